// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding, PC step,
// fetch FSM state encodings and the {PC, INS} prefetch entry type.
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INS = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FS_FETCH   = 2'd0,
    FS_DISCARD = 2'd1,
    FS_HALT    = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  // Instruction fetches are word aligned; low PC bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO of {PC, INS} entries. Head is read straight from the storage
// registers. Flush empties the FIFO and wins over a same-cycle push or pop.
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full || pop_ok);

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Entry storage; contents of empty slots are never observed.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, runs a req/ack handshake to
// instruction memory, buffers words in a prefetch FIFO and handles redirects.
// Optional feature macro FETCH_MISALIGN_CHK_EN: misaligned redirects raise a
// sticky FETCH_ERR and halt fetching until an aligned redirect arrives.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INS,
  output logic [31:0] PC_OUT,
  output logic        INS_VALID,
  input  logic        INS_READY,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        FETCH_ERR
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      discard_addr_q, discard_addr_d;
  logic [31:0]      target_pc;
  logic             redirect_bad;
  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;

  assign target_pc = align_pc(REDIRECT_PC);

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q;

  assign redirect_bad = (REDIRECT_PC[1:0] != 2'b00);

  // Sticky error: any redirect rewrites it with its own alignment status.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (REDIRECT) begin
      err_q <= redirect_bad;
    end
  end

  assign FETCH_ERR = err_q;
`else
  assign redirect_bad = 1'b0;
  assign FETCH_ERR    = 1'b0;
`endif

  // State register: FSM state, fetch PC and the address of a request being discarded.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= FS_FETCH;
      fetch_pc_q     <= RESET_PC;
      discard_addr_q <= RESET_PC;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      discard_addr_q <= discard_addr_d;
    end
  end

  // Next-state logic; redirect has priority over the normal PC advance.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    discard_addr_d = discard_addr_q;
    unique case (state_q)
      FS_FETCH: begin
        if (REDIRECT) begin
          fetch_pc_d = target_pc;
          if (IMEM_REQ && !IMEM_ACK) begin
            // Request in flight must complete at its original address.
            state_d        = FS_DISCARD;
            discard_addr_d = fetch_pc_q;
          end else if (redirect_bad) begin
            state_d = FS_HALT;
          end
        end else if (fifo_push) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
        end
      end
      FS_DISCARD: begin
        if (REDIRECT) fetch_pc_d = target_pc;
        if (IMEM_ACK) begin
          state_d = (REDIRECT ? redirect_bad : FETCH_ERR) ? FS_HALT : FS_FETCH;
        end
      end
      FS_HALT: begin
        if (REDIRECT) begin
          fetch_pc_d = target_pc;
          if (!redirect_bad) state_d = FS_FETCH;
        end
      end
      default: state_d = FS_FETCH;
    endcase
  end

  // Memory request outputs; space is checked before a request is raised.
  always_comb begin
    IMEM_REQ  = 1'b0;
    IMEM_ADDR = fetch_pc_q;
    unique case (state_q)
      FS_FETCH:   IMEM_REQ = !RST && !fifo_full;
      FS_DISCARD: begin
        IMEM_REQ  = !RST;
        IMEM_ADDR = discard_addr_q;
      end
      FS_HALT:    IMEM_REQ = 1'b0;
      default:    IMEM_REQ = 1'b0;
    endcase
  end

  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_push  = (state_q == FS_FETCH) && IMEM_REQ && IMEM_ACK;
  assign fifo_pop   = INS_VALID && INS_READY;
  assign push_entry = '{pc: fetch_pc_q, ins: IMEM_RDATA};

  instr_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .flush_i     (REDIRECT),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign INS_VALID = !fifo_empty;
  assign INS       = INS_VALID ? fifo_head.ins : NOP_INS;
  assign PC_OUT    = INS_VALID ? fifo_head.pc : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Memory data is addr ^ 32'hA5A5_0000; ACK is
// driven cycle by cycle. Inputs change just after the falling edge and outputs
// are sampled 1ns later, well before the next rising edge.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] pc_out;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;
  int pushes;

  localparam logic [31:0] XMASK = 32'hA5A5_0000;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ XMASK;

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .IMEM_REQ    (imem_req),
    .IMEM_ADDR   (imem_addr),
    .IMEM_ACK    (imem_ack),
    .IMEM_RDATA  (imem_rdata),
    .INS         (ins),
    .PC_OUT      (pc_out),
    .INS_VALID   (ins_valid),
    .INS_READY   (ins_ready),
    .REDIRECT    (redirect),
    .REDIRECT_PC (redirect_pc),
    .FETCH_ERR   (fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to the next cycle's drive point.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b0;
    ins_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset values
    next_cycle(); next_cycle(); settle();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_ins", ins, 32'h0000_0013);
    check("rst_pc", pc_out, 32'h0);
    check("rst_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);

    // Streaming: ACK tied 1, READY 1 -> one instruction per cycle
    next_cycle(); rst = 1'b0; imem_ack = 1'b1; ins_ready = 1'b1; settle();
    check("s0_req", {31'd0, imem_req}, 32'd1);
    check("s0_addr", imem_addr, 32'h0);
    check("s0_valid", {31'd0, ins_valid}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      next_cycle(); settle();
      check("s_addr", imem_addr, 32'(4 * k));
      check("s_valid", {31'd0, ins_valid}, 32'd1);
      check("s_pc", pc_out, 32'(4 * (k - 1)));
      check("s_ins", ins, 32'(4 * (k - 1)) ^ XMASK);
    end

    // Drain: request for 24 stays pending while the head (20) is consumed
    next_cycle(); imem_ack = 1'b0; settle();
    check("d_pc", pc_out, 32'd20);
    check("d_addr", imem_addr, 32'd24);

    // Backpressure for 10 cycles: exactly two pushes then REQ drops
    pushes = 0;
    for (int c = 0; c < 10; c++) begin
      next_cycle(); ins_ready = 1'b0; imem_ack = 1'b1; settle();
      if (imem_req && imem_ack) pushes++;
      if (c >= 2) begin
        check("bp_req", {31'd0, imem_req}, 32'd0);
        check("bp_pc", pc_out, 32'd24);
        check("bp_ins", ins, 32'd24 ^ XMASK);
      end
    end
    check("bp_pushes", 32'(pushes), 32'd2);
    next_cycle(); ins_ready = 1'b1; settle();
    check("rel_pc0", pc_out, 32'd24);
    check("rel_req0", {31'd0, imem_req}, 32'd0);
    next_cycle(); settle();
    check("rel_pc1", pc_out, 32'd28);
    check("rel_addr1", imem_addr, 32'd32);
    next_cycle(); settle();
    check("rel_pc2", pc_out, 32'd32);
    check("rel_addr2", imem_addr, 32'd36);

    // Slow memory plus redirect to 0x100 while a request is in flight
    next_cycle(); imem_ack = 1'b0; settle();
    check("lat_req", {31'd0, imem_req}, 32'd1);
    check("lat_addr0", imem_addr, 32'd40);
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h100; settle();
    check("lat_addr1", imem_addr, 32'd40);
    next_cycle(); redirect = 1'b0; settle();
    check("disc_addr", imem_addr, 32'd40);
    check("disc_req", {31'd0, imem_req}, 32'd1);
    next_cycle(); imem_ack = 1'b1; settle();
    check("disc_ack_addr", imem_addr, 32'd40);
    for (int c = 0; c < 3; c++) begin
      next_cycle(); imem_ack = 1'b0; settle();
      check("tgt_addr", imem_addr, 32'h100);
      check("tgt_valid", {31'd0, ins_valid}, 32'd0);
    end
    next_cycle(); imem_ack = 1'b1; settle();
    check("tgt_ack_addr", imem_addr, 32'h100);
    next_cycle(); imem_ack = 1'b0; settle();
    check("tgt_valid1", {31'd0, ins_valid}, 32'd1);
    check("tgt_pc", pc_out, 32'h100);
    check("tgt_ins", ins, 32'hA5A5_0100);

    // Redirect coincident with ACK and pop
    next_cycle(); imem_ack = 1'b1; ins_ready = 1'b0; settle();
    check("co_addr0", imem_addr, 32'h104);
    next_cycle(); ins_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; settle();
    check("co_pc", pc_out, 32'h104);
    check("co_addr1", imem_addr, 32'h108);
    next_cycle(); redirect = 1'b0; imem_ack = 1'b0; settle();
    check("co_valid", {31'd0, ins_valid}, 32'd0);
    check("co_ins", ins, 32'h0000_0013);
    check("co_pcout", pc_out, 32'h0);
    check("co_req", {31'd0, imem_req}, 32'd1);
    check("co_addr2", imem_addr, 32'h200);

    // PC wraparound
    next_cycle(); imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
    check("wr_addr0", imem_addr, 32'h200);
    next_cycle(); redirect = 1'b0; settle();
    check("wr_addr1", imem_addr, 32'hFFFF_FFFC);
    check("wr_valid", {31'd0, ins_valid}, 32'd0);
    next_cycle(); settle();
    check("wr_addr2", imem_addr, 32'h0);
    check("wr_pc", pc_out, 32'hFFFF_FFFC);
    check("wr_ins", ins, 32'h5A5A_FFFC);
    next_cycle(); settle();
    check("wr_addr3", imem_addr, 32'h4);
    check("wr_pc1", pc_out, 32'h0);

    // Misaligned redirect
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h102; settle();
    check("mis_addr0", imem_addr, 32'h8);
    next_cycle(); redirect = 1'b0; imem_ack = 1'b0; settle();
    check("mis_valid", {31'd0, ins_valid}, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_err", {31'd0, fetch_err}, 32'd1);
    check("mis_req", {31'd0, imem_req}, 32'd0);
`else
    check("mis_err", {31'd0, fetch_err}, 32'd0);
    check("mis_req", {31'd0, imem_req}, 32'd1);
    check("mis_addr", imem_addr, 32'h100);
`endif
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h200; imem_ack = 1'b1; settle();
`ifdef FETCH_MISALIGN_CHK_EN
    check("halt_req", {31'd0, imem_req}, 32'd0);
    check("halt_err", {31'd0, fetch_err}, 32'd1);
`else
    check("mis_addr1", imem_addr, 32'h100);
`endif
    next_cycle(); redirect = 1'b0; settle();
    check("res_err", {31'd0, fetch_err}, 32'd0);
    check("res_req", {31'd0, imem_req}, 32'd1);
    check("res_addr", imem_addr, 32'h200);
    next_cycle(); settle();
    check("res_valid", {31'd0, ins_valid}, 32'd1);
    check("res_pc", pc_out, 32'h200);

    // Reset in the middle of streaming abandons the transfer
    next_cycle(); rst = 1'b1; imem_ack = 1'b0; settle();
    check("mrst_req", {31'd0, imem_req}, 32'd0);
    check("mrst_valid", {31'd0, ins_valid}, 32'd0);
    check("mrst_addr", imem_addr, 32'h0);
    next_cycle(); rst = 1'b0; settle();
    check("mrst_req1", {31'd0, imem_req}, 32'd1);
    check("mrst_addr1", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit. Produces the 32-bit INS word consumed by the control decoder and the datapath.
- Owns the PC and runs a req/ack handshake to instruction memory.
- Buffers fetched words in a small prefetch FIFO.
- Accepts jump/branch redirects from execute and flushes stale instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, ≥2).

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  32  fetch address, word aligned.
- IMEM_ACK  in  1  request completed, IMEM_RDATA valid this cycle.
- IMEM_RDATA  in  32  instruction word.
- INS  out  32  instruction to decoder (FIFO head).
- PC_OUT  out  32  PC of INS.
- INS_VALID  out  1  INS/PC_OUT valid.
- INS_READY  in  1  decode stage consumes head when INS_VALID is also high.
- REDIRECT  in  1  jump/branch taken.
- REDIRECT_PC  in  32  target PC.
- FETCH_ERR  out  1  misaligned redirect (optional feature; otherwise tied 0).

Behaviour:
- Reset is asynchronous and active-high on RST. Reset values:
  - fetch_pc = RESET_PC, FIFO empty, state = FETCH.
  - IMEM_REQ = 0, IMEM_ADDR = RESET_PC.
  - INS = NOP (32'h0000_0013), PC_OUT = 0, INS_VALID = 0, FETCH_ERR = 0.
- Reset mid-transfer abandons any outstanding request.
- FSM states:
  - FETCH: IMEM_REQ = (fifo_count < FIFO_DEPTH); IMEM_ADDR = fetch_pc.
  - DISCARD: IMEM_REQ held at 1 with the old address until IMEM_ACK; returned data is dropped; then go to FETCH.
  - HALT: optional-feature only; IMEM_REQ = 0.
- Memory handshake:
  - Once raised, IMEM_REQ and IMEM_ADDR stay stable until IMEM_ACK.
  - IMEM_ACK may arrive in the same cycle as REQ or any later cycle.
  - At most one request is outstanding.
  - ACK in FETCH pushes {fetch_pc, IMEM_RDATA} and advances fetch_pc by 4. The next REQ may follow in the very next cycle, so sustained throughput is 1 instruction/cycle.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Output stage:
  - INS_VALID = FIFO not empty.
  - INS/PC_OUT come from the registered FIFO head.
  - INS = NOP whenever the FIFO is empty.
  - Pop occurs when INS_VALID && INS_READY. Push and pop may happen in the same cycle.
- Full FIFO: no REQ is issued, so no overflow is possible. The space check is made before the request, and only the single outstanding request can push.
- Redirect (highest priority, takes effect at the next edge):
  - FIFO flushed; any same-cycle push is dropped; a same-cycle pop is still counted as consumed.
  - fetch_pc = REDIRECT_PC with bits [1:0] cleared.
  - If REQ is pending and not ACKed in the redirect cycle, go to DISCARD; otherwise go to FETCH.
  - REDIRECT in DISCARD updates fetch_pc and stays in DISCARD.
- Latency:
  - Redirect at cycle N: REQ for the target at N+1 (no discard); INS_VALID at N+2 at the earliest with zero-wait memory.
  - After reset release: REQ at the first cycle; INS_VALID the following cycle with zero-wait memory.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - A REDIRECT with REDIRECT_PC[1:0] != 0 sets FETCH_ERR (sticky), flushes the FIFO and enters HALT (after DISCARD if needed).
  - HALT issues no requests.
  - A later aligned REDIRECT clears FETCH_ERR and resumes FETCH.
- Undefined: low PC bits are silently masked and FETCH_ERR is tied 0.

Decomposition:
- Shared define.v gains:
  - NOP_INS = 32'h0000_0013.
  - FSM state encodings FS_FETCH, FS_DISCARD, FS_HALT.
  - PC_STEP = 4.
- Sub-module fetch_fifo: a synchronous FIFO of {PC, INS} with push, pop, flush, count, and head outputs; depth FIFO_DEPTH.

Test Plan:
- Reset release, IMEM_ACK tied 1, RDATA = addr^32'hA5A5_0000, INS_READY = 1 -> REQ addresses 0,4,8,… on consecutive cycles; INS_VALID from cycle 2 with matching PC_OUT/INS; no gaps.
- INS_READY = 0 for 10 cycles -> exactly FIFO_DEPTH pushes, then IMEM_REQ = 0; INS held stable; on release, order is preserved with no loss or duplication.
- 3-cycle ACK latency, REDIRECT to 32'h100 in the cycle after REQ -> REQ/ADDR held until ACK, that data dropped; next REQ addresses 32'h100; first INS_VALID carries PC_OUT = 32'h100.
- REDIRECT coincident with ACK and pop -> pushed word discarded, FIFO empty next cycle, INS = NOP, REQ to target the next cycle.
- Redirect to 32'hFFFF_FFFC, ACK held 1 -> fetch addresses FFFF_FFFC then 0000_0000.
- With FETCH_MISALIGN_CHK_EN, REDIRECT_PC = 32'h102 -> FETCH_ERR = 1, no REQ; then REDIRECT_PC = 32'h200 -> FETCH_ERR = 0, fetch resumes at 32'h200. Without the macro -> fetch at 32'h100, FETCH_ERR = 0.
